lea_serial_sub_ctrl: RTL and testbench
======================================

LEA_SERIAL_SUB_CTRL -- requirements
Module: lea_serial_sub_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result word width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: clr_i  input  1  synchronous abort; discards any operation in flight.
REQ-005 Port: start_i  input  1  request valid; operands on a_i/b_i/bin_i are valid.
REQ-006 Port: ready_o  output  1  block can accept a request this cycle.
REQ-007 Port: a_i  input  WIDTH  minuend.
REQ-008 Port: b_i  input  WIDTH  subtrahend.
REQ-009 Port: bin_i  input  1  initial borrow-in.
REQ-010 Port: busy_o  output  1  serial subtraction in progress.
REQ-011 Port: out_valid_o  output  1  result on d_o/bout_o is valid.
REQ-012 Port: out_ready_i  input  1  consumer accepts the result.
REQ-013 Port: d_o  output  WIDTH  difference, a - b - bin mod 2^WIDTH.
REQ-014 Port: bout_o  output  1  final borrow; 1 iff a < b + bin (unsigned).

Function
REQ-015 The block SHALL compute the difference bit-serially, LSB first, one bit per cycle, through exactly one 1-bit full-subtractor cell, with the borrow held in a flop between bits.
REQ-016 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-017 IDLE: ready_o=1, busy_o=0, out_valid_o=0; start_i=1 captures a_i, b_i, bin_i into shift/borrow registers, clears the bit counter, and moves to RUN.
REQ-018 RUN: ready_o=0, busy_o=1; each cycle, bit 0 of the A and B shift registers and the borrow flop feed the cell; the difference bit shifts into the result register at the MSB end; the borrow flop takes the cell borrow-out; the counter increments.
REQ-019 RUN SHALL last exactly WIDTH cycles; on the edge that processes bit WIDTH-1 the state moves to DONE.
REQ-020 Latency: out_valid_o SHALL rise exactly WIDTH cycles after the accepting edge (start_i & ready_o).
REQ-021 DONE: out_valid_o=1; d_o and bout_o SHALL be stable until out_ready_i=1; on out_valid_o & out_ready_i the state moves to IDLE.
REQ-022 ready_o SHALL be 1 only in IDLE; start_i in RUN or DONE is ignored and SHALL NOT disturb operands or result.
REQ-023 clr_i=1 in any state SHALL force IDLE on the next edge; no result is produced for the discarded operation.
REQ-024 clr_i and start_i asserted together in IDLE: clr_i wins; no capture occurs.
REQ-025 clr_i and out_ready_i asserted together in DONE: return to IDLE; the result counts as discarded.
REQ-026 Wrap-around SHALL be modulo 2^WIDTH; borrow out of bit WIDTH-1 appears only on bout_o.
REQ-027 d_o and bout_o SHALL hold their last values outside DONE, and are not qualified outside DONE.

Reset
REQ-028 When rst=1 on an edge: state=IDLE, counter=0, borrow flop=0, result register=0; outputs are then ready_o=1, busy_o=0, out_valid_o=0, d_o=0, bout_o=0.
REQ-029 rst mid-RUN or in DONE SHALL abort the operation identically to clr_i, and SHALL also clear the result.
REQ-030 rst SHALL take priority over clr_i, start_i and out_ready_i.

Structure
REQ-031 Shared package lea_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE) and the default word width constant LEA_WORD_W=32.
REQ-032 The counter width SHALL be $clog2(WIDTH); no adder wider than 1 bit is permitted in the datapath.
REQ-033 The 1-bit full-subtractor cell SHALL be a separate sub-module, lea_fullsub_bit (inputs a, b, bin; outputs d, bout), instantiated once.

Verification
REQ-034 WIDTH=32, a=5, b=3, bin=0, out_ready_i=1 -> out_valid_o rises 32 cycles after accept; d_o=0x00000002, bout_o=0.
REQ-035 a=0, b=1, bin=0 -> d_o=0xFFFFFFFF, bout_o=1; and a=0xFFFFFFFF, b=0xFFFFFFFF, bin=1 -> d_o=0xFFFFFFFF, bout_o=1.
REQ-036 Backpressure: out_ready_i=0 for 10 cycles in DONE -> out_valid_o, d_o, bout_o stay stable; ready_o=0; a start_i pulse in this window is ignored.
REQ-037 clr_i at RUN cycle 16 -> IDLE next cycle, no out_valid_o; a new request a=7, b=7, bin=0 then yields d_o=0, bout_o=0.
REQ-038 rst at RUN cycle 5, then at reset release -> all outputs at reset values; start_i and clr_i together in IDLE -> no capture, busy_o stays 0.
REQ-039 Random 1000 requests with a reference model (a-b-bin), random out_ready_i -> all results match; back-to-back accepts spaced at least WIDTH+2 cycles.

Source files
------------

// File: rtl/lea_pkg.sv
// Shared types and constants for the LEA serial arithmetic blocks.
package lea_pkg;

  localparam int LEA_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lea_state_t;

endpackage

// File: rtl/lea_fullsub_bit.sv
// 1-bit full subtractor: d = a - b - bin, with borrow out.
module lea_fullsub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_x;

  assign w_x  = a ^ b;
  assign d    = w_x ^ bin;
  assign bout = (~a & b) | (~w_x & bin);

endmodule

// File: rtl/lea_serial_sub_ctrl.sv
// Bit-serial subtractor, LSB first, one bit per cycle,
// with request/result handshakes and abort.
module lea_serial_sub_ctrl
  import lea_pkg::*;
#(
  parameter int WIDTH = LEA_WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             start_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] d_o,
  output logic             bout_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  lea_state_t       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_bor;
  logic             r_ready;
  logic             r_busy;
  logic             r_valid;
  logic             w_d;
  logic             w_bout;

  lea_fullsub_bit u_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_bor),
    .d    (w_d),
    .bout (w_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_bor   <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else if (clr_i) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_a     <= a_i;
            r_b     <= b_i;
            r_bor   <= bin_i;
            r_cnt   <= '0;
            r_state <= RUN;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_bor <= w_bout;
          r_d   <= {w_d, r_d[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o     = r_ready;
  assign busy_o      = r_busy;
  assign out_valid_o = r_valid;
  assign d_o         = r_d;
  assign bout_o      = r_bor;

endmodule

// File: tb/tb_lea_serial_sub_ctrl.sv
// Self-checking bench for lea_serial_sub_ctrl against an
// arithmetic reference model.
module tb_lea_serial_sub_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr_i;
  logic         start_i;
  logic         ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         bin_i;
  logic         busy_o;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] d_o;
  logic         bout_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lea_serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr_i),
    .start_i     (start_i),
    .ready_o     (ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .bin_i       (bin_i),
    .busy_o      (busy_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .d_o         (d_o),
    .bout_o      (bout_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] model(
    input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W:0] full;
    logic [W:0] rhs;
    rhs  = {1'b0, b} + {{W{1'b0}}, bin};
    full = {1'b0, a} - rhs;
    return {({1'b0, a} < rhs), full[W-1:0]};
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input int hold, input bit poke,
                        input string tag);
    logic [W:0] exp;
    int n;
    exp = model(a, b, bin);
    a_i = a; b_i = b; bin_i = bin; start_i = 1'b1; out_ready_i = 1'b0;
    step();
    start_i = 1'b0;
    a_i = $urandom; b_i = $urandom; bin_i = 1'($urandom);
    n_chk++;
    if (busy_o !== 1'b1 || ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: busy=%b ready=%b want busy=1 ready=0",
               tag, busy_o, ready_o);
    end
    n = 0;
    while (out_valid_o !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    n_chk++;
    if (n !== W) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", tag, n, W);
    end
    for (int k = 0; k <= hold; k++) begin
      if (poke && k == 2) begin
        start_i = 1'b1;
        a_i = $urandom; b_i = $urandom; bin_i = 1'($urandom);
      end
      n_chk++;
      if (out_valid_o !== 1'b1 || ready_o !== 1'b0 ||
          d_o !== exp[W-1:0] || bout_o !== exp[W]) begin
        n_fail++;
        $display("FAIL %s result[%0d]: ov=%b rdy=%b d=%h bout=%b want ov=1 rdy=0 d=%h bout=%b",
                 tag, k, out_valid_o, ready_o, d_o, bout_o, exp[W-1:0], exp[W]);
      end
      if (k < hold) step();
      start_i = 1'b0;
    end
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    n_chk++;
    if (ready_o !== 1'b1 || out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release: rdy=%b ov=%b busy=%b want rdy=1 ov=0 busy=0",
               tag, ready_o, out_valid_o, busy_o);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    n_chk++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0 || out_valid_o !== 1'b0 ||
        d_o !== '0 || bout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: rdy=%b busy=%b ov=%b d=%h bout=%b want 1 0 0 0 0",
               tag, ready_o, busy_o, out_valid_o, d_o, bout_o);
    end
  endtask

  task automatic no_valid_for(input int cycles, input string tag);
    int seen = 0;
    for (int k = 0; k < cycles; k++) begin
      step();
      if (out_valid_o === 1'b1 || busy_o === 1'b1) seen++;
    end
    n_chk++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL %s: active cycles %0d want 0", tag, seen);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_i = 1'b0; start_i = 1'b0; out_ready_i = 1'b0;
    a_i = '0; b_i = '0; bin_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_idle_reset("reset_state");
    step();
    check_idle_reset("reset_idle_hold");
  endtask

  task automatic test_basic();
    run_op(32'd5, 32'd3, 1'b0, 0, 1'b0, "basic_5_3");
  endtask

  task automatic test_wrap();
    run_op(32'd0, 32'd1, 1'b0, 0, 1'b0, "wrap_0_1");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1, 1'b0, "wrap_ff_ff_b");
    run_op(32'hFFFF_FFFF, 32'd0, 1'b1, 0, 1'b0, "max_minus_bin");
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0, 1'b0, "msb_only");
  endtask

  task automatic test_backpressure();
    run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 10, 1'b1, "backpressure");
  endtask

  task automatic test_clear();
    a_i = 32'hDEAD_BEEF; b_i = 32'h1; bin_i = 1'b0; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 0; k < 16; k++) step();
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    n_chk++;
    if (ready_o !== 1'b1 || busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_mid_run: rdy=%b busy=%b ov=%b want 1 0 0",
               ready_o, busy_o, out_valid_o);
    end
    no_valid_for(W + 4, "clr_no_result");
    run_op(32'd7, 32'd7, 1'b0, 0, 1'b0, "after_clr_7_7");
  endtask

  task automatic test_rst_mid_run();
    a_i = 32'hCAFE_0001; b_i = 32'h0000_0101; bin_i = 1'b1; start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1; clr_i = 1'b1; out_ready_i = 1'b1;
    step();
    rst = 1'b0; clr_i = 1'b0; out_ready_i = 1'b0;
    check_idle_reset("rst_mid_run");
    start_i = 1'b1; clr_i = 1'b1; a_i = 32'd9; b_i = 32'd1;
    step();
    start_i = 1'b0; clr_i = 1'b0;
    check_idle_reset("clr_beats_start");
    no_valid_for(W + 4, "clr_start_no_capture");
  endtask

  task automatic test_clr_in_done();
    logic [W:0] exp;
    int n;
    exp = model(32'd100, 32'd1, 1'b0);
    a_i = 32'd100; b_i = 32'd1; bin_i = 1'b0; start_i = 1'b1;
    step();
    start_i = 1'b0;
    n = 0;
    while (out_valid_o !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    n_chk++;
    if (n !== W || d_o !== exp[W-1:0]) begin
      n_fail++;
      $display("FAIL clr_done_setup: lat=%0d d=%h want lat=%0d d=%h",
               n, d_o, W, exp[W-1:0]);
    end
    clr_i = 1'b1; out_ready_i = 1'b1;
    step();
    clr_i = 1'b0; out_ready_i = 1'b0;
    n_chk++;
    if (ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_in_done: rdy=%b ov=%b want 1 0", ready_o, out_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom; b = $urandom; bin = 1'($urandom);
      if (i % 7 == 0) b = a;
      if (i % 11 == 0) a = '0;
      run_op(a, b, bin, int'($urandom_range(0, 3)), 1'($urandom), "random");
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_clear();
    test_rst_mid_run();
    test_clr_in_done();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
